// File: rtl/flag_stack_reg.sv
// Condition-flag register with per-flag write masking, optional write-through
// and a LIFO save/restore stack for nested interrupt entry and return.
module flag_stack_reg #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    parameter int PW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_mask,
    input  logic [WIDTH-1:0] write_data,
    input  logic             save,
    input  logic             restore,
    input  logic             err_clear,
    output logic [WIDTH-1:0] read_data,
    output logic [PW-1:0]    depth_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH-1:0] stack_top;
    logic             save_only;
    logic             restore_only;
    logic             do_push;
    logic             do_pop;

    assign merged        = (flags & ~write_mask) | (write_data & write_mask);
    assign stack_full    = (depth_count == PW'(DEPTH));
    assign stack_empty   = (depth_count == '0);
    assign save_only     = save & ~restore;
    assign restore_only  = restore & ~save;
    assign do_push       = save_only & ~stack_full;
    assign do_pop        = restore_only & ~stack_empty;

    // Entry just below depth_count; explicit compare keeps the index width exact.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_count == PW'(i + 1))
                stack_top = stack_mem[i];
        end
    end

    always_comb begin
        read_data = flags;
        if (BYPASS != 0 && write_enable && !restore_only)
            read_data = merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags       <= '0;
            depth_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                stack_mem[i] <= '0;
        end else begin
            if (do_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (depth_count == PW'(i))
                        stack_mem[i] <= flags;
                end
                depth_count <= depth_count + PW'(1);
            end else if (do_pop) begin
                depth_count <= depth_count - PW'(1);
            end

            // Any restore-only cycle blocks the write, even a failed pop on empty.
            if (do_pop)
                flags <= stack_top;
            else if (write_enable && !restore_only)
                flags <= merged;
        end
    end

    // A fresh error in the same cycle as err_clear leaves the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (save_only && stack_full)
                overflow_err <= 1'b1;
            else if (err_clear)
                overflow_err <= 1'b0;

            if (restore_only && stack_empty)
                underflow_err <= 1'b1;
            else if (err_clear)
                underflow_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flag_stack_reg.sv
// Directed self-checking bench for flag_stack_reg; a BYPASS=0 copy shares the
// inputs so write-through and registered-only read paths are checked side by side.
module tb_flag_stack_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [2:0] write_mask;
    logic [2:0] write_data;
    logic       save;
    logic       restore;
    logic       err_clear;

    logic [2:0] read_data,     read_data_nb;
    logic [2:0] depth_count,   depth_count_nb;
    logic       stack_full,    stack_full_nb;
    logic       stack_empty,   stack_empty_nb;
    logic       overflow_err,  overflow_err_nb;
    logic       underflow_err, underflow_err_nb;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    flag_stack_reg #(.WIDTH(3), .DEPTH(4), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_mask(write_mask), .write_data(write_data),
        .save(save), .restore(restore), .err_clear(err_clear),
        .read_data(read_data), .depth_count(depth_count),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    flag_stack_reg #(.WIDTH(3), .DEPTH(4), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_mask(write_mask), .write_data(write_data),
        .save(save), .restore(restore), .err_clear(err_clear),
        .read_data(read_data_nb), .depth_count(depth_count_nb),
        .stack_full(stack_full_nb), .stack_empty(stack_empty_nb),
        .overflow_err(overflow_err_nb), .underflow_err(underflow_err_nb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] mask,
                                 input logic [2:0] data, input logic sv,
                                 input logic rs, input logic ec);
        write_enable = we;
        write_mask   = mask;
        write_data   = data;
        save         = sv;
        restore      = rs;
        err_clear    = ec;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeFlags(input logic [2:0] value);
        applyStimulus(1'b1, 3'b111, value, 1'b0, 1'b0, 1'b0);
        stepClock();
        idle();
    endtask

    task automatic doSave();
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        stepClock();
        idle();
    endtask

    task automatic doRestore();
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        stepClock();
        idle();
    endtask

    logic [2:0] pushVals [4];
    logic [2:0] popVals  [4];

    initial begin
        pushVals = '{3'b001, 3'b010, 3'b011, 3'b100};
        popVals  = '{3'b100, 3'b011, 3'b010, 3'b001};
        reset = 1'b1;
        idle();
        #12;
        checkOutput("reset_read",  read_data,     0);
        checkOutput("reset_depth", depth_count,   0);
        checkOutput("reset_empty", stack_empty,   1);
        checkOutput("reset_full",  stack_full,    0);
        checkOutput("reset_ovf",   overflow_err,  0);
        checkOutput("reset_unf",   underflow_err, 0);
        reset = 1'b0;

        // Masked write: same-cycle write-through on BYPASS=1 only.
        applyStimulus(1'b1, 3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bypass_comb",    read_data,    3'b101);
        checkOutput("nobypass_comb",  read_data_nb, 3'b000);
        stepClock();
        idle();
        checkOutput("bypass_after",   read_data,    3'b101);
        checkOutput("nobypass_after", read_data_nb, 3'b101);
        applyStimulus(1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mask0_comb", read_data, 3'b101);
        stepClock();
        idle();
        checkOutput("mask0_after", read_data, 3'b101);

        // Save, overwrite, restore.
        writeFlags(3'b010);
        doSave();
        checkOutput("save_depth", depth_count, 1);
        writeFlags(3'b111);
        checkOutput("write_after_save", read_data, 3'b111);
        doRestore();
        checkOutput("restore_read",  read_data,   3'b010);
        checkOutput("restore_depth", depth_count, 0);
        checkOutput("restore_empty", stack_empty, 1);

        // Fill the stack, overflow, then unwind in LIFO order.
        for (int i = 0; i < 4; i++) begin
            writeFlags(pushVals[i]);
            doSave();
        end
        checkOutput("fill_full",  stack_full,   1);
        checkOutput("fill_depth", depth_count,  4);
        checkOutput("fill_ovf",   overflow_err, 0);
        doSave();
        checkOutput("ovf_err",   overflow_err, 1);
        checkOutput("ovf_depth", depth_count,  4);
        for (int i = 0; i < 4; i++) begin
            doRestore();
            checkOutput($sformatf("pop%0d", i), read_data, popVals[i]);
        end
        checkOutput("unwind_empty", stack_empty, 1);
        checkOutput("unwind_unf",   underflow_err, 0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        stepClock();
        idle();
        checkOutput("ovf_cleared", overflow_err, 0);

        // Restore on empty: write blocked, underflow sticky, clear priority.
        applyStimulus(1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("unf_comb_read", read_data, 3'b001);
        stepClock();
        idle();
        checkOutput("unf_read",  read_data,     3'b001);
        checkOutput("unf_err",   underflow_err, 1);
        checkOutput("unf_depth", depth_count,   0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("unf_cleared", underflow_err, 0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
        stepClock();
        idle();
        checkOutput("unf_clear_loses", underflow_err, 1);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        stepClock();
        idle();

        // Save and restore together: stack untouched, write applies.
        writeFlags(3'b011);
        doSave();
        writeFlags(3'b101);
        doSave();
        applyStimulus(1'b1, 3'b111, 3'b110, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("both_comb", read_data, 3'b110);
        stepClock();
        idle();
        checkOutput("both_depth", depth_count,   2);
        checkOutput("both_read",  read_data,     3'b110);
        checkOutput("both_ovf",   overflow_err,  0);
        checkOutput("both_unf",   underflow_err, 0);
        // Pop then push on the very next cycle, no bubble.
        doRestore();
        checkOutput("both_pop", read_data, 3'b101);
        doSave();
        checkOutput("repush_depth", depth_count, 2);
        doRestore();
        checkOutput("repush_pop", read_data, 3'b101);
        doRestore();
        checkOutput("both_pop2", read_data, 3'b011);

        // Asynchronous reset in the middle of a cycle with a loaded stack.
        doSave();
        doSave();
        doSave();
        writeFlags(3'b111);
        checkOutput("pre_reset_depth", depth_count, 3);
        checkOutput("pre_reset_read",  read_data,   3'b111);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_read",     read_data,    0);
        checkOutput("async_read_nb",  read_data_nb, 0);
        checkOutput("async_depth",    depth_count,  0);
        checkOutput("async_empty",    stack_empty,  1);
        checkOutput("async_full",     stack_full,   0);
        #2;
        reset = 1'b0;
        // Cleared stack entries: a fresh push/pop of zero flags returns zero.
        doSave();
        writeFlags(3'b110);
        doRestore();
        checkOutput("post_reset_pop", read_data, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/flag_stack_reg.md
# flag_stack_reg

Parametrised condition-flag register with per-flag write masking, optional same-cycle write-through, and a LIFO save/restore stack for nested interrupt entry and return. It sits between the ALU/writeback stage, which produces flag updates, and the execute and branch logic, which consumes them. The interrupt controller drives `save` on interrupt entry and `restore` on return-from-interrupt. It replaces the fixed 3-bit flag register with a block that also preserves flags across interrupts.

## Interface
- WIDTH, 3, number of flag bits (bit0 Z, bit1 N, bit2 C by convention; block is agnostic)
- DEPTH, 4, save-stack entries (≥1)
- BYPASS, 1, 1 = `read_data` reflects a same-cycle write combinationally; 0 = registered value only
- PW, $clog2(DEPTH+1), derived width of `depth_count`

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- write_enable  in  1  apply masked flag update this cycle
- write_mask  in  WIDTH  per-flag enable; bit=1 → flag takes `write_data` bit
- write_data  in  WIDTH  new flag values
- save  in  1  push current flag register onto stack
- restore  in  1  pop top of stack into flag register
- err_clear  in  1  clear sticky error bits
- read_data  out  WIDTH  current flags (see BYPASS)
- depth_count  out  PW  entries currently on stack, 0..DEPTH
- stack_full  out  1  depth_count == DEPTH
- stack_empty  out  1  depth_count == 0
- overflow_err  out  1  sticky: save attempted while full
- underflow_err  out  1  sticky: restore attempted while empty

## Operation
- merged = (flags & ~write_mask) | (write_data & write_mask); write with all-zero mask leaves flags unchanged.
- Per-edge actions, mutually exclusive, evaluated on `save`/`restore`:
  - Neither: if write_enable, flags ← merged.
  - save only, not full: stack[depth_count] ← flags (pre-write value); depth_count+1. Flags still take merged if write_enable.
  - save only, full: no push, stack untouched, overflow_err ← 1; write still applies.
  - restore only, not empty: flags ← stack[depth_count-1]; depth_count−1. write_enable ignored this cycle (restore wins).
  - restore only, empty: no pop, flags unchanged (write_enable ignored), underflow_err ← 1.
  - save and restore together: stack and depth_count unchanged, no error; write applies as "neither" case.
- err_clear clears both sticky bits; a new error event in the same cycle wins (bit ends set).
- read_data: BYPASS=1 and write_enable and no effective restore (restore low, or save&restore both high) → merged; otherwise flags register. BYPASS=0 → flags register always.
- stack_full/stack_empty are pure decodes of depth_count.

## Timing
- Reset (async assert, any time, including mid push/pop): flags=0, depth_count=0, all stack entries=0, overflow_err=underflow_err=0 → read_data=0, stack_empty=1, stack_full=0. First update on first rising edge after reset deasserts.
- Write latency: 0 cycles to read_data with BYPASS=1; 1 cycle (visible after the edge) with BYPASS=0.
- Push/pop latency: 1 edge; depth_count and flags update at that edge. Pop followed immediately by push on the next cycle is legal with no bubble.
- Back-to-back saves to DEPTH: the DEPTH-th save sets stack_full after its edge; the (DEPTH+1)-th sets overflow_err after its edge.
- Error flags register at the offending edge; no combinational path from save/restore to error outputs.

## Test plan
- Reset then write_enable=1, mask=3'b101, data=3'b111, BYPASS=1 → read_data=3'b101 same cycle; still 3'b101 after edge; mask=0 write → unchanged.
- Flags=3'b010, save → depth_count=1; write 3'b111 full mask; restore → read_data=3'b010, depth_count=0, stack_empty=1.
- DEPTH=4: push 3'b001,3'b010,3'b011,3'b100 → stack_full=1; 5th save → overflow_err=1, depth_count=4; four restores return 100,011,010,001 in order.
- Restore on empty with write_enable=1 data=3'b111 → flags unchanged, underflow_err=1; err_clear next cycle → 0; err_clear with simultaneous empty restore → stays 1.
- save and restore both high, depth_count=2, write 3'b110 full mask → depth_count=2, flags=3'b110, no errors.
- Assert reset asynchronously mid-cycle with depth_count=3, flags=3'b111 → outputs go to reset values before next edge; BYPASS=0 build: write visible only after the edge.
